// File: rtl/clkdiv_pkg.sv
// Shared defaults and types for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned DEFAULT_DIV_DEF = 1_000_000;

  typedef logic [CNT_W_DEF-1:0] div_t;

  // Channel-select width, never narrower than one bit.
  function automatic int unsigned ch_sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: shadow/active divisor pair, period counter and registered outputs.
module div_channel #(
  parameter int unsigned      CNT_W   = 32,
  parameter logic [CNT_W-1:0] RST_DIV = '0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [CNT_W-1:0] shd_q, shd_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             running;
  logic             wrap;

  // Next-state: divisor changes only land on a wrap edge, using the pre-write shadow.
  always_comb begin
    shd_d   = wr ? wr_div : shd_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    running = en && (act_q != '0);
    wrap    = (cnt_q == (act_q - One)) || sync;
    if (!running) begin
      // Idle channels sit one count before wrap so enabling starts a fresh period.
      act_d = shd_q;
      cnt_d = shd_q - One;
    end else if (wrap) begin
      cnt_d  = '0;
      act_d  = shd_q;
      tick_d = 1'b1;
      clk_d  = (shd_q >> 1) != '0;
    end else begin
      cnt_d = cnt_q + One;
      clk_d = (cnt_q + One) < (act_q >> 1);
    end
    pend_d = (shd_d != act_d);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      shd_q  <= RST_DIV;
      act_q  <= RST_DIV;
      cnt_q  <= RST_DIV - One;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: write decode and sync fan-out around div_channel.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter div_t        DEFAULT_DIV = div_t'(DEFAULT_DIV_DEF),
  localparam int unsigned SEL_W      = ch_sel_w(CHANNELS)
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    wr_ch,
  input  logic [CNT_W-1:0]    wr_div,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pend
);

  localparam logic [CNT_W-1:0] RstDiv = DEFAULT_DIV[CNT_W-1:0];

  logic [CHANNELS-1:0] wr_sel;

  // Write decode; out-of-range channel numbers match nothing and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_sel[i] = wr_en && (wr_ch == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    div_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (RstDiv)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (ch_en[g]),
      .sync    (sync),
      .wr      (wr_sel[g]),
      .wr_div  (wr_div),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pend    (pend[g])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: vector table, directed corners, random vs model.
module tb_prog_clock_divider;

  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int DDIV = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [CW-1:0]  wr_div;
  logic [NCH-1:0] ch_en;
  logic           sync;
  logic [NCH-1:0] clk_out, tick, pend;

  // Second instance with a non-power-of-two channel count for out-of-range writes.
  logic           wr_en5;
  logic [2:0]     wr_ch5;
  logic [4:0]     ch_en5;
  logic [4:0]     clk_out5, tick5, pend5;

  always #5 clk = ~clk;

  prog_clock_divider #(.CHANNELS(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .clk_in (clk), .rst (rst), .wr_en (wr_en), .wr_ch (wr_ch), .wr_div (wr_div),
    .ch_en (ch_en), .sync (sync), .clk_out (clk_out), .tick (tick), .pend (pend)
  );

  prog_clock_divider #(.CHANNELS(5), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut5 (
    .clk_in (clk), .rst (rst), .wr_en (wr_en5), .wr_ch (wr_ch5), .wr_div (wr_div),
    .ch_en (ch_en5), .sync (sync), .clk_out (clk_out5), .tick (tick5), .pend (pend5)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per channel, divisors plus position within the current period.
  int unsigned    m_shd[NCH];
  int unsigned    m_act[NCH];
  int unsigned    m_pos[NCH];
  logic [NCH-1:0] e_clk, e_tick, e_pend;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_shd[i] = DDIV; m_act[i] = DDIV; m_pos[i] = DDIV - 1;
        e_clk[i] = 1'b0; e_tick[i] = 1'b0; e_pend[i] = 1'b0;
      end else begin
        int unsigned old_shd;
        old_shd = m_shd[i];
        if (ch_en[i] && m_act[i] != 0) begin
          int unsigned nxt;
          bit w;
          nxt = (m_pos[i] + 1) % m_act[i];
          w   = (nxt == 0) || sync;
          if (w) begin
            m_pos[i] = 0;
            m_act[i] = old_shd;
          end else begin
            m_pos[i] = nxt;
          end
          e_tick[i] = w;
          e_clk[i]  = m_pos[i] < (m_act[i] / 2);
        end else begin
          m_act[i]  = old_shd;
          m_pos[i]  = (old_shd - 1) & 32'hFFFF;
          e_tick[i] = 1'b0;
          e_clk[i]  = 1'b0;
        end
        if (wr_en && int'(wr_ch) == i) m_shd[i] = wr_div;
        e_pend[i] = (m_shd[i] != m_act[i]);
      end
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1ns later and compared.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("clk_out", 32'(clk_out), 32'(e_clk));
    check("tick",    32'(tick),    32'(e_tick));
    check("pend",    32'(pend),    32'(e_pend));
  endtask

  typedef struct {
    logic           r;
    logic [NCH-1:0] en;
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;
  } vec_t;

  vec_t tbl[9];
  int   hi, tk, hi2, tk2, any3;

  initial begin
    // Reset, then ch0 alone at the default divisor of 4: 1100 repeating.
    tbl[0] = '{1'b1, 4'b0001, 4'b0000, 4'b0000};
    tbl[1] = '{1'b0, 4'b0001, 4'b0001, 4'b0001};
    tbl[2] = '{1'b0, 4'b0001, 4'b0001, 4'b0000};
    tbl[3] = '{1'b0, 4'b0001, 4'b0000, 4'b0000};
    tbl[4] = '{1'b0, 4'b0001, 4'b0000, 4'b0000};
    tbl[5] = '{1'b0, 4'b0001, 4'b0001, 4'b0001};
    tbl[6] = '{1'b0, 4'b0001, 4'b0001, 4'b0000};
    tbl[7] = '{1'b0, 4'b0001, 4'b0000, 4'b0000};
    tbl[8] = '{1'b0, 4'b0001, 4'b0000, 4'b0000};

    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; ch_en = '0; sync = 1'b0;
    wr_en5 = 1'b0; wr_ch5 = '0; ch_en5 = '0;
    cycle();
    cycle();
    check("reset pend", 32'(pend), 32'h0);

    for (int i = 0; i < 9; i++) begin
      rst   = tbl[i].r;
      ch_en = tbl[i].en;
      cycle();
      check($sformatf("tbl%0d clk_out", i), 32'(clk_out), 32'(tbl[i].exp_clk));
      check($sformatf("tbl%0d tick", i),    32'(tick),    32'(tbl[i].exp_tick));
    end

    // Divisor change mid-period: old period finishes, then 6-cycle periods with 3 high.
    cycle();
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd6;
    cycle();
    wr_en = 1'b0;
    check("pend after write", 32'(pend[0]), 32'h1);
    cycle();
    check("pend held 1", 32'(pend[0]), 32'h1);
    cycle();
    check("pend held 2", 32'(pend[0]), 32'h1);
    cycle();
    check("wrap at 4", 32'(tick[0]), 32'h1);
    check("pend cleared", 32'(pend[0]), 32'h0);
    hi = int'(clk_out[0]);
    tk = 0;
    for (int k = 1; k < 6; k++) begin
      cycle();
      hi += int'(clk_out[0]);
      tk += int'(tick[0]);
    end
    check("D6 high time", 32'(hi), 32'd3);
    check("D6 no early tick", 32'(tk), 32'd0);
    cycle();
    check("D6 period", 32'(tick[0]), 32'h1);

    // D=5 on ch1, D=1 on ch2, D=0 on ch3.
    wr_en = 1'b1;
    wr_ch = 2'd1; wr_div = 16'd5; cycle();
    wr_ch = 2'd2; wr_div = 16'd1; cycle();
    wr_ch = 2'd3; wr_div = 16'd0; cycle();
    wr_en = 1'b0;
    cycle();
    ch_en = 4'b1111;
    hi = 0; tk = 0; hi2 = 0; tk2 = 0; any3 = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      hi   += int'(clk_out[1]);
      tk   += int'(tick[1]);
      hi2  += int'(clk_out[2]);
      tk2  += int'(tick[2]);
      any3 += int'(clk_out[3]) + int'(tick[3]) + int'(pend[3]);
    end
    check("D5 high count", 32'(hi), 32'd4);
    check("D5 ticks", 32'(tk), 32'd2);
    check("D1 high count", 32'(hi2), 32'd0);
    check("D1 ticks", 32'(tk2), 32'd10);
    check("D0 activity", 32'(any3), 32'd0);

    // Drift ch0 at 4 against ch1 at 6, then sync.
    wr_en = 1'b1;
    wr_ch = 2'd0; wr_div = 16'd4; cycle();
    wr_ch = 2'd1; wr_div = 16'd6; cycle();
    wr_en = 1'b0;
    for (int k = 0; k < 13; k++) cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    check("sync tick", 32'(tick[1:0]), 32'h3);
    check("sync clk", 32'(clk_out[1:0]), 32'h3);
    check("sync idle ch3", 32'(tick[3]), 32'h0);

    // Reset mid-period, then restart at the default divisor.
    cycle();
    rst = 1'b1;
    cycle();
    check("rst clk_out", 32'(clk_out), 32'h0);
    check("rst tick", 32'(tick), 32'h0);
    check("rst pend", 32'(pend), 32'h0);
    rst = 1'b0;
    cycle();
    check("restart tick", 32'(tick), 32'hF);
    check("restart clk", 32'(clk_out), 32'hF);

    // Out-of-range writes on the 5-channel instance are dropped.
    wr_en5 = 1'b1; wr_ch5 = 3'd5; cycle();
    check("oor5 pend", 32'(pend5), 32'h0);
    wr_ch5 = 3'd7; cycle();
    check("oor7 pend", 32'(pend5), 32'h0);
    wr_ch5 = 3'd4; wr_div = 16'd7; cycle();
    check("ch4 write pend", 32'(pend5), 32'h10);
    wr_en5 = 1'b0; cycle();
    check("ch4 applied", 32'(pend5), 32'h0);
    check("dut5 idle out", 32'({clk_out5, tick5}), 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst    = ($urandom % 60) == 0;
      wr_en  = ($urandom % 4) == 0;
      wr_ch  = 2'($urandom_range(0, 3));
      wr_div = 16'($urandom_range(0, 9));
      sync   = ($urandom % 25) == 0;
      if (($urandom % 16) == 0) ch_en = 4'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
